// File: rtl/fb_word_unpacker.sv
// fb_word_unpacker: serialises packed framebuffer words into one pixel per beat
// and tracks the raster position, with start-of-frame / end-of-line /
// end-of-frame markers. A shared flush drops the held word and rewinds the
// raster to (0,0).
module fb_word_unpacker #(
  parameter int WordW = 32,
  parameter int PixW  = 8,
  parameter int HRes  = 640,
  parameter int VRes  = 480,
  parameter int XW    = $clog2(HRes),
  parameter int YW    = $clog2(VRes)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WordW-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [PixW-1:0]  pix_o,
  output logic [XW-1:0]    x_o,
  output logic [YW-1:0]    y_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             eof_o
);

  localparam int L  = WordW / PixW;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(L - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(HRes - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(VRes - 1);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WordW-1:0]  word_q;
  logic [LW-1:0]     lane_q, lane_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              full;
  logic              last_lane;
  logic              pix_fire;
  logic              in_fire;

  // Next-state logic: flush beats a new word, a new word beats the last-lane drain
  always_comb begin
    full      = (state_q == HOLD);
    last_lane = (lane_q == LAST_LANE);
    pix_fire  = full && ready_i;
    ready_o   = !flush_i && (!full || (pix_fire && last_lane));
    in_fire   = valid_i && ready_o;
    state_d   = state_q;
    lane_d    = lane_q;
    x_d       = x_q;
    y_d       = y_q;

    if (pix_fire) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (flush_i) begin
      state_d = EMPTY;
      lane_d  = '0;
      x_d     = '0;
      y_d     = '0;
    end else if (in_fire) begin
      state_d = HOLD;
      lane_d  = '0;
    end else if (pix_fire) begin
      if (last_lane) begin
        state_d = EMPTY;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // Control state: occupancy, lane pointer and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      lane_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Word holding register: data only, loaded on acceptance, never reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      word_q <= data_i;
    end
  end

  // Outputs come from registers only; the pixel is blanked while empty
  assign valid_o = full;
  assign pix_o   = full ? word_q[lane_q*PixW +: PixW] : '0;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign sof_o   = full && (x_q == '0) && (y_q == '0);
  assign eol_o   = full && (x_q == X_LAST);
  assign eof_o   = eol_o && (y_q == Y_LAST);

endmodule

// File: tb/tb_fb_word_unpacker.sv
// Testbench for fb_word_unpacker: directed vector table, hand-written corner
// sequences and a random run, with a scoreboard of expected pixels/positions.
module tb_fb_word_unpacker;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  pix_o;
  logic [2:0]  x_o;
  logic [0:0]  y_o;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;

  int checks = 0;
  int errors = 0;

  fb_word_unpacker #(
    .WordW(32), .PixW(8), .HRes(8), .VRes(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .pix_o(pix_o), .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o),
    .eof_o(eof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: one entry per pixel, positions counted in acceptance order
  typedef struct packed {
    logic [7:0] pix;
    logic [2:0] x;
    logic       y;
    logic       sof;
    logic       eol;
    logic       eof;
  } sb_t;

  sb_t sb_q[$];
  int  mx = 0;
  int  my = 0;

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb_q.delete();
      mx = 0;
      my = 0;
    end else begin
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pixel", 64'(pix_o), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("sb_pixel", 64'({pix_o, x_o, y_o, sof_o, eol_o, eof_o}), 64'(e));
        end
      end
      if (!valid_o) check("idle_flags", 64'({sof_o, eol_o, eof_o}), 64'(0));
      if (flush_i) begin
        sb_q.delete();
        mx = 0;
        my = 0;
      end else if (valid_i && ready_o) begin
        for (int l = 0; l < 4; l++) begin
          e.pix = data_i[l*8 +: 8];
          e.x   = 3'(mx);
          e.y   = 1'(my);
          e.sof = (mx == 0) && (my == 0);
          e.eol = (mx == 7);
          e.eof = (mx == 7) && (my == 1);
          sb_q.push_back(e);
          if (mx == 7) begin
            mx = 0;
            my = (my == 1) ? 0 : my + 1;
          end else begin
            mx = mx + 1;
          end
        end
      end
    end
  end

  // Directed per-cycle vectors
  typedef struct {
    logic        vi;
    logic [31:0] data;
    logic        ri;
    logic        fl;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [16:0] ex(input logic vo, input logic [7:0] pix, input logic [2:0] x,
                                     input logic y, input logic sof, input logic eol,
                                     input logic eof, input logic ro);
    return {vo, pix, x, y, sof, eol, eof, ro};
  endfunction

  logic [7:0] seq_b = 8'h10;

  // Stream n pixels with valid_i/ready_i high; optionally check frame markers
  task automatic run_pixels(input int n, input bit chk_frame);
    int fired = 0;
    int guard = 0;
    while (fired < n && guard < 200) begin
      valid_i = 1'b1;
      data_i  = {seq_b + 8'd3, seq_b + 8'd2, seq_b + 8'd1, seq_b};
      ready_i = 1'b1;
      flush_i = 1'b0;
      @(negedge clk);
      if (valid_o && ready_i) begin
        if (chk_frame) begin
          check("frame_pos", 64'({x_o, y_o}), 64'({3'(fired % 8), 1'((fired / 8) % 2)}));
          check("frame_marks", 64'({sof_o, eof_o}), 64'({fired % 16 == 0, fired == 15}));
        end
        fired++;
      end
      if (valid_i && ready_o) seq_b = seq_b + 8'd4;
      tick();
      guard++;
    end
    if (fired < n) check("stream_timeout", 64'(fired), 64'(n));
    valid_i = 1'b0;
    ready_i = 1'b0;
  endtask

  task automatic do_flush();
    tick();
    flush_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    int sent;
    int guard;
    bit acc;

    tbl[0]  = '{1'b1, 32'h44332211, 1'b1, 1'b0, ex(0, 8'h00, 0, 0, 0, 0, 0, 1)};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h11, 0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h22, 1, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h33, 2, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h44, 3, 0, 0, 0, 0, 1)};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, ex(0, 8'h00, 4, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b1, 32'h04030201, 1'b1, 1'b0, ex(0, 8'h00, 0, 0, 0, 0, 0, 1)};
    tbl[7]  = '{1'b1, 32'h08070605, 1'b1, 1'b0, ex(1, 8'h01, 0, 0, 1, 0, 0, 0)};
    tbl[8]  = '{1'b1, 32'h08070605, 1'b1, 1'b0, ex(1, 8'h02, 1, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b1, 32'h08070605, 1'b1, 1'b0, ex(1, 8'h03, 2, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b1, 32'h08070605, 1'b1, 1'b0, ex(1, 8'h04, 3, 0, 0, 0, 0, 1)};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h05, 4, 0, 0, 0, 0, 0)};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h06, 5, 0, 0, 0, 0, 0)};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h07, 6, 0, 0, 0, 0, 0)};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b0, ex(1, 8'h08, 7, 0, 0, 1, 0, 1)};

    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 64'({valid_o, pix_o, x_o, y_o, sof_o, eol_o, eof_o}), 64'(0));

    // Asynchronous reset while a word is held mid-line
    tick(); valid_i = 1'b1; data_i = 32'hA3A2A1A0; ready_i = 1'b1;
    tick(); valid_i = 1'b0;
    tick();
    tick(); ready_i = 1'b0;
    @(negedge clk);
    check("pre_reset_hold", 64'({valid_o, pix_o, x_o}), 64'({1'b1, 8'hA2, 3'd2}));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'({valid_o, x_o, y_o}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table: first word, flush, back-to-back words
    for (int i = 0; i < 15; i++) begin
      tick();
      valid_i = tbl[i].vi; data_i = tbl[i].data; ready_i = tbl[i].ri; flush_i = tbl[i].fl;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({valid_o, pix_o, x_o, y_o, sof_o, eol_o, eof_o, ready_o}), 64'(tbl[i].exp));
    end
    tick(); valid_i = 1'b0; flush_i = 1'b0;

    // Backpressure on lane 2 (line 1)
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; ready_i = 1'b1;
    @(negedge clk);
    check("bp_accept", 64'(ready_o), 64'(1));
    tick(); valid_i = 1'b0;
    @(negedge clk);
    check("bp_lane0", 64'({valid_o, pix_o, x_o, y_o}), 64'({1'b1, 8'hAA, 3'd0, 1'b1}));
    tick();
    tick(); ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stall", 64'({valid_o, pix_o, x_o, y_o, ready_o}), 64'({1'b1, 8'hCC, 3'd2, 1'b1, 1'b0}));
      tick();
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_resume", 64'({pix_o, x_o}), 64'({8'hCC, 3'd2}));
    tick();
    @(negedge clk);
    check("bp_next", 64'({pix_o, x_o, ready_o}), 64'({8'hDD, 3'd3, 1'b1}));

    // Frame wrap: 17 pixels from frame start
    do_flush();
    run_pixels(17, 1'b1);

    // Flush with a word held at lane 1, position x=5 y=1
    do_flush();
    run_pixels(13, 1'b0);
    @(negedge clk);
    check("fl_pre", 64'({valid_o, x_o, y_o}), 64'({1'b1, 3'd5, 1'b1}));
    tick(); flush_i = 1'b1;
    @(negedge clk);
    check("fl_cycle", 64'({ready_o, valid_o, x_o, y_o}), 64'({1'b0, 1'b1, 3'd5, 1'b1}));
    tick(); flush_i = 1'b0;
    @(negedge clk);
    check("fl_after", 64'({valid_o, x_o, y_o, sof_o}), 64'(0));
    tick(); valid_i = 1'b1; data_i = 32'h0D0C0B0A; ready_i = 1'b1;
    @(negedge clk);
    check("fl_accept", 64'(ready_o), 64'(1));
    tick(); valid_i = 1'b0;
    @(negedge clk);
    check("fl_restart", 64'({valid_o, pix_o, x_o, y_o, sof_o}), 64'({1'b1, 8'h0A, 3'd0, 1'b0, 1'b1}));
    repeat (4) tick();

    // Random valid/ready over 1000 words
    sent = 0;
    guard = 0;
    valid_i = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!valid_i && $urandom_range(0, 3) != 0) begin
        valid_i = 1'b1;
        data_i  = $urandom;
      end
      ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = valid_i && ready_o;
      tick();
      if (acc) begin
        sent++;
        valid_i = 1'b0;
      end
      guard++;
    end
    check("rand_words", 64'(sent), 64'(1000));
    valid_i = 1'b0;
    ready_i = 1'b1;
    guard = 0;
    while ((sb_q.size() != 0 || valid_o) && guard < 100) begin
      tick();
      guard++;
    end
    check("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
